// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, legal prescale ratios,
// default data width and the parity-type encoding used by both directions.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

  localparam int DATA_WD_DEF = 8;

  // PAR_TYP encoding
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter with three-point majority sampling around mid-bit.
// The prescale ratio is captured on the start-edge detect and held for the frame.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int Prescale_Wd = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx,
  input  logic                   start,
  input  logic                   en,
  input  logic                   clr,
  input  logic [Prescale_Wd-1:0] prescale,
  output logic                   bit_val,
  output logic                   bit_mid,
  output logic                   bit_end
);

  localparam logic [Prescale_Wd-1:0] ONE = Prescale_Wd'(1);

  logic [Prescale_Wd-1:0] p_q;
  logic [Prescale_Wd-1:0] edge_cnt;
  logic [Prescale_Wd-1:0] half;
  logic [Prescale_Wd-1:0] mid_at;
  logic [Prescale_Wd-1:0] last_at;
  logic                   s0;
  logic                   s1;

  assign half    = p_q >> 1;
  assign mid_at  = half + ONE;
  assign last_at = p_q - ONE;

  assign bit_mid = en && (edge_cnt == mid_at);
  assign bit_end = en && (edge_cnt == last_at);
  // Third sample is the live line value at P/2+1; decision made in that cycle
  assign bit_val = maj3(s0, s1, rx);

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q      <= Prescale_Wd'(PRESCALE_8);
      edge_cnt <= '0;
      s0       <= 1'b1;
      s1       <= 1'b1;
    end else begin
      if (start) p_q <= prescale;
      if (clr || bit_end) edge_cnt <= '0;
      else if (en)        edge_cnt <= edge_cnt + ONE;
      if (edge_cnt == half - ONE) s0 <= rx;
      if (edge_cnt == half)       s1 <= rx;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizer, frame FSM, shift register and stop/parity checks.
// Parity support is compiled in with UART_RX_PARITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int Data_Wd     = DATA_WD_DEF,
  parameter int Prescale_Wd = 6
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   RX_IN,
  input  logic [Prescale_Wd-1:0] Prescale,
`ifdef UART_RX_PARITY_EN
  input  logic                   PAR_EN,
  input  logic                   PAR_TYP,
`endif
  output logic [Data_Wd-1:0]     P_DATA,
  output logic                   Data_Valid,
  output logic                   Par_Err,
  output logic                   Stp_Err
);

  localparam int BC_W = (Data_Wd > 1) ? $clog2(Data_Wd) : 1;

  rx_state_t          state_q;
  rx_state_t          state_d;
  logic [1:0]         sync_q;
  logic               rx_s;
  logic               start_det;
  logic               smp_en;
  logic               smp_clr;
  logic               bit_val;
  logic               bit_mid;
  logic               bit_end;
  logic [BC_W-1:0]    bit_cnt;
  logic               last_bit;
  logic [Data_Wd-1:0] shreg;
  logic               stp_bad;
  logic               par_fail;
  logic               done;
  logic               good;

  always_ff @(posedge CLK) begin
    if (RST) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], RX_IN};
  end
  assign rx_s = sync_q[1];

  assign start_det = (state_q == ST_IDLE) && !rx_s;
  assign smp_en    = (state_q != ST_IDLE) || start_det;
  // A start bit that votes high was a glitch: restart the edge counter
  assign smp_clr   = (state_q == ST_START) && bit_mid && bit_val;
  assign last_bit  = (bit_cnt == BC_W'(Data_Wd - 1));

  uart_rx_sampler #(
    .Prescale_Wd(Prescale_Wd)
  ) u_sampler (
    .clk     (CLK),
    .rst     (RST),
    .rx      (rx_s),
    .start   (start_det),
    .en      (smp_en),
    .clr     (smp_clr),
    .prescale(Prescale),
    .bit_val (bit_val),
    .bit_mid (bit_mid),
    .bit_end (bit_end)
  );

  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!rx_s) state_d = ST_START;
      ST_START: begin
        if (bit_mid && bit_val) state_d = ST_IDLE;
        else if (bit_end)       state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end && last_bit) begin
`ifdef UART_RX_PARITY_EN
          state_d = PAR_EN ? ST_PARITY : ST_STOP;
`else
          state_d = ST_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: if (bit_end) state_d = ST_STOP;
`endif
      ST_STOP:  if (bit_end) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  logic par_bad;
  always_ff @(posedge CLK) begin
    if (RST)                                        par_bad <= 1'b0;
    else if (start_det)                             par_bad <= 1'b0;
    else if ((state_q == ST_PARITY) && bit_mid)     par_bad <= bit_val ^ (^shreg) ^ PAR_TYP;
  end
  assign par_fail = par_bad;
`else
  assign par_fail = 1'b0;
`endif

  assign good = done && !stp_bad && !par_fail;

  // Results are registered one cycle after the STOP->IDLE transition
  always_ff @(posedge CLK) begin
    if (RST) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      stp_bad    <= 1'b0;
      done       <= 1'b0;
      P_DATA     <= '0;
      Data_Valid <= 1'b0;
      Par_Err    <= 1'b0;
      Stp_Err    <= 1'b0;
    end else begin
      done       <= (state_q == ST_STOP) && bit_end;
      Data_Valid <= good;
      Par_Err    <= done && par_fail;
      Stp_Err    <= done && stp_bad;
      if (good) P_DATA <= shreg;
      if (start_det) bit_cnt <= '0;
      if (state_q == ST_DATA) begin
        if (bit_mid) shreg <= {bit_val, shreg[Data_Wd-1:1]};
        if (bit_end) bit_cnt <= bit_cnt + BC_W'(1);
      end
      if ((state_q == ST_STOP) && bit_mid) stp_bad <= !bit_val;
    end
  end

endmodule
